// File: rtl/accumulator_binary_commander_pkg.sv
// Shared definitions for the accumulator command initiator: op encoding and FSM states.
package accumulator_binary_commander_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

endpackage

// File: rtl/accumulator_binary_commander_quiet_counter.sv
// Post-reset quiet window: counts down from LOAD_VALUE after reset and
// reports quiet while any count remains, so stale done pulses from an
// operation interrupted by reset are absorbed.
module accumulator_binary_commander_quiet_counter #(
    parameter int unsigned LOAD_VALUE = 1
) (
    input  logic i_clock,
    input  logic i_reset_n,
    output logic o_quiet
);

    localparam int unsigned CW = (LOAD_VALUE < 1) ? 1 : $clog2(LOAD_VALUE + 1);
    localparam logic [CW-1:0] LOAD = CW'(LOAD_VALUE);

    logic [CW-1:0] r_count;

    // Load on reset, then count down once per cycle and stop at zero.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= LOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_quiet = (r_count != '0);

endmodule

// File: rtl/accumulator_binary_commander.sv
// Initiator for the signed binary accumulator's pulse/done protocol.
// Takes one command at a time, issues exactly one single-cycle pulse,
// waits for the matching done and returns the captured result. Every
// output comes straight from a register.
module accumulator_binary_commander
    import accumulator_binary_commander_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned ACC_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WORD_WIDTH-1:0] cmd_value,
    input  logic                  cmd_carry_in,
    output logic                  acc_clear,
    output logic                  acc_increment_valid,
    output logic                  acc_increment_add_sub,
    output logic                  acc_increment_carry_in,
    output logic [WORD_WIDTH-1:0] acc_increment_value,
    output logic                  acc_load_valid,
    output logic [WORD_WIDTH-1:0] acc_load_value,
    input  logic                  acc_clear_done,
    input  logic                  acc_increment_done,
    input  logic                  acc_load_done,
    input  logic [WORD_WIDTH-1:0] acc_accumulated_value,
    input  logic                  acc_carry_out,
    input  logic                  acc_signed_overflow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_op,
    output logic [WORD_WIDTH-1:0] rsp_value,
    output logic                  rsp_carry_out,
    output logic                  rsp_overflow,
    output logic                  protocol_error
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;
    logic                  w_quiet;
    logic                  w_done_sel;
    logic                  w_done_any;
    logic                  w_done_multi;
    logic                  w_done_match;
    logic                  w_done_error;

    logic [1:0]            r_op;
    logic                  r_cmd_ready;
    logic                  r_clear;
    logic                  r_inc_valid;
    logic                  r_inc_add_sub;
    logic                  r_inc_carry_in;
    logic [WORD_WIDTH-1:0] r_inc_value;
    logic                  r_load_valid;
    logic [WORD_WIDTH-1:0] r_load_value;
    logic                  r_rsp_valid;
    logic [1:0]            r_rsp_op;
    logic [WORD_WIDTH-1:0] r_rsp_value;
    logic                  r_rsp_carry_out;
    logic                  r_rsp_overflow;
    logic                  r_protocol_error;

    accumulator_binary_commander_quiet_counter #(
        .LOAD_VALUE (ACC_LATENCY)
    ) u_quiet (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .o_quiet   (w_quiet)
    );

    // Pick the done pulse that completes the latched op.
    always_comb begin
        w_done_sel = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB: w_done_sel = acc_increment_done;
            OP_LOAD:        w_done_sel = acc_load_done;
            default:        w_done_sel = acc_clear_done;
        endcase
    end

    // Done classification; everything is suppressed inside the quiet window.
    assign w_done_any   = acc_clear_done | acc_increment_done | acc_load_done;
    assign w_done_multi = (acc_clear_done & acc_increment_done) |
                          (acc_clear_done & acc_load_done) |
                          (acc_increment_done & acc_load_done);
    assign w_done_match = !w_quiet && (r_state == WAIT) && w_done_sel;
    assign w_done_error = !w_quiet && w_done_any &&
                          !((r_state == WAIT) && w_done_sel && !w_done_multi);

    // Next-state logic for the one-command-at-a-time handshake.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (w_done_match) w_state_next = RESPOND;
            RESPOND: if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered outputs: command latch, pulses, response capture and sticky error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op             <= OP_ADD;
            r_cmd_ready      <= 1'b0;
            r_clear          <= 1'b0;
            r_inc_valid      <= 1'b0;
            r_inc_add_sub    <= 1'b0;
            r_inc_carry_in   <= 1'b0;
            r_inc_value      <= '0;
            r_load_valid     <= 1'b0;
            r_load_value     <= '0;
            r_rsp_valid      <= 1'b0;
            r_rsp_op         <= OP_ADD;
            r_rsp_value      <= '0;
            r_rsp_carry_out  <= 1'b0;
            r_rsp_overflow   <= 1'b0;
            r_protocol_error <= 1'b0;
        end else begin
            r_cmd_ready  <= (w_state_next == IDLE);
            r_rsp_valid  <= (w_state_next == RESPOND);
            r_clear      <= w_accept && (cmd_op == OP_CLEAR);
            r_inc_valid  <= w_accept && ((cmd_op == OP_ADD) || (cmd_op == OP_SUB));
            r_load_valid <= w_accept && (cmd_op == OP_LOAD);
            if (w_accept) begin
                r_op           <= cmd_op;
                r_inc_add_sub  <= cmd_op[0] & ~cmd_op[1];
                r_inc_carry_in <= cmd_carry_in & ~cmd_op[1];
                r_inc_value    <= cmd_value;
                r_load_value   <= cmd_value;
            end
            if (w_done_match) begin
                r_rsp_op        <= r_op;
                r_rsp_value     <= acc_accumulated_value;
                r_rsp_carry_out <= acc_carry_out;
                r_rsp_overflow  <= acc_signed_overflow;
            end
            if (w_done_error) begin
                r_protocol_error <= 1'b1;
            end
        end
    end

    assign cmd_ready              = r_cmd_ready;
    assign acc_clear              = r_clear;
    assign acc_increment_valid    = r_inc_valid;
    assign acc_increment_add_sub  = r_inc_add_sub;
    assign acc_increment_carry_in = r_inc_carry_in;
    assign acc_increment_value    = r_inc_value;
    assign acc_load_valid         = r_load_valid;
    assign acc_load_value         = r_load_value;
    assign rsp_valid              = r_rsp_valid;
    assign rsp_op                 = r_rsp_op;
    assign rsp_value              = r_rsp_value;
    assign rsp_carry_out          = r_rsp_carry_out;
    assign rsp_overflow           = r_rsp_overflow;
    assign protocol_error         = r_protocol_error;

endmodule

// File: tb/tb_accumulator_binary_commander.sv
// Bench for accumulator_binary_commander: two instances (latency 1 and 3),
// each attached to a behavioural accumulator with an injectable done path.
`timescale 1ns/1ps
module tb_accumulator_binary_commander;

    localparam int W    = 8;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam logic [1:0] K_ADD = 2'b00, K_SUB = 2'b01, K_LOAD = 2'b10, K_CLEAR = 2'b11;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int lat [2];

    logic         reset_n [2];
    logic         cmd_valid [2], cmd_ready [2], cmd_carry_in [2];
    logic [1:0]   cmd_op [2];
    logic [W-1:0] cmd_value [2];
    logic         acc_clear [2], acc_inc_valid [2], acc_inc_add_sub [2], acc_inc_cin [2], acc_load_valid [2];
    logic [W-1:0] acc_inc_value [2], acc_load_value [2];
    logic         clear_done [2], inc_done [2], load_done [2];
    logic         md_clear [2], md_inc [2], md_load [2], md_carry [2], md_ovf [2];
    logic [W-1:0] md_value [2];
    logic         inj_clear [2], inj_inc [2], inj_load [2];
    logic         rsp_valid [2], rsp_ready [2], rsp_carry_out [2], rsp_overflow [2], protocol_error [2];
    logic [1:0]   rsp_op [2];
    logic [W-1:0] rsp_value [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign clear_done[g] = md_clear[g] | inj_clear[g];
        assign inc_done[g]   = md_inc[g]   | inj_inc[g];
        assign load_done[g]  = md_load[g]  | inj_load[g];

        accumulator_binary_commander #(
            .WORD_WIDTH  (W),
            .ACC_LATENCY ((g == 0) ? LAT0 : LAT1)
        ) u_dut (
            .clock                  (clock),
            .reset_n                (reset_n[g]),
            .cmd_valid              (cmd_valid[g]),
            .cmd_ready              (cmd_ready[g]),
            .cmd_op                 (cmd_op[g]),
            .cmd_value              (cmd_value[g]),
            .cmd_carry_in           (cmd_carry_in[g]),
            .acc_clear              (acc_clear[g]),
            .acc_increment_valid    (acc_inc_valid[g]),
            .acc_increment_add_sub  (acc_inc_add_sub[g]),
            .acc_increment_carry_in (acc_inc_cin[g]),
            .acc_increment_value    (acc_inc_value[g]),
            .acc_load_valid         (acc_load_valid[g]),
            .acc_load_value         (acc_load_value[g]),
            .acc_clear_done         (clear_done[g]),
            .acc_increment_done     (inc_done[g]),
            .acc_load_done          (load_done[g]),
            .acc_accumulated_value  (md_value[g]),
            .acc_carry_out          (md_carry[g]),
            .acc_signed_overflow    (md_ovf[g]),
            .rsp_valid              (rsp_valid[g]),
            .rsp_ready              (rsp_ready[g]),
            .rsp_op                 (rsp_op[g]),
            .rsp_value              (rsp_value[g]),
            .rsp_carry_out          (rsp_carry_out[g]),
            .rsp_overflow           (rsp_overflow[g]),
            .protocol_error         (protocol_error[g])
        );
    end

    // Signed accumulator arithmetic: add = a+b+cin, subtract = a-b-cin (carry = borrow).
    function automatic void acc_step(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, output logic [W-1:0] r, output logic c, output logic o);
        int s;
        r = '0; c = 1'b0; o = 1'b0;
        case (op)
            K_ADD: begin
                s = int'(a) + int'(b) + int'(cin);
                r = W'(s); c = (s >= (1 << W));
                o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            K_SUB: begin
                s = int'(a) - int'(b) - int'(cin);
                r = W'(s); c = (s < 0);
                o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            K_LOAD: r = b;
            default: r = '0;
        endcase
    endfunction

    // Behavioural accumulator: done and result appear lat[n] cycles after the pulse.
    typedef struct packed { logic vld; logic [1:0] kind; logic [W-1:0] val; logic c; logic o; } ev_t;
    ev_t          pipe [2][5];
    logic [W-1:0] acc_state [2];
    int           n_pulse [2], last_pulse_cyc [2];
    logic [1:0]   last_kind [2];
    logic [1:0]   m_kind;
    logic [W-1:0] m_v, m_in;
    logic         m_c, m_o, m_cin;

    always @(negedge clock) begin
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 4; i++) pipe[n][i] = pipe[n][i+1];
            pipe[n][4]  = '0;
            md_clear[n] = pipe[n][0].vld && (pipe[n][0].kind == K_CLEAR);
            md_load[n]  = pipe[n][0].vld && (pipe[n][0].kind == K_LOAD);
            md_inc[n]   = pipe[n][0].vld && !pipe[n][0].kind[1];
            if (pipe[n][0].vld) begin
                md_value[n] = pipe[n][0].val;
                md_carry[n] = pipe[n][0].c;
                md_ovf[n]   = pipe[n][0].o;
            end
            n_pulse[n] += int'(acc_clear[n]) + int'(acc_inc_valid[n]) + int'(acc_load_valid[n]);
            if (acc_clear[n] || acc_inc_valid[n] || acc_load_valid[n]) begin
                m_kind = acc_clear[n] ? K_CLEAR : acc_load_valid[n] ? K_LOAD : {1'b0, acc_inc_add_sub[n]};
                m_in   = acc_load_valid[n] ? acc_load_value[n] : acc_inc_value[n];
                m_cin  = acc_inc_cin[n];
                acc_step(m_kind, acc_state[n], m_in, m_cin, m_v, m_c, m_o);
                acc_state[n]      = m_v;
                pipe[n][lat[n]]   = '{vld: 1'b1, kind: m_kind, val: m_v, c: m_c, o: m_o};
                last_pulse_cyc[n] = cyc;
                last_kind[n]      = m_kind;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    function automatic logic [63:0] outs_vec(input int n);
        return 64'({cmd_ready[n], acc_clear[n], acc_inc_valid[n], acc_inc_add_sub[n], acc_inc_cin[n],
                    acc_inc_value[n], acc_load_valid[n], acc_load_value[n], rsp_valid[n], rsp_op[n],
                    rsp_value[n], rsp_carry_out[n], rsp_overflow[n], protocol_error[n]});
    endfunction

    logic [W-1:0] exp_acc [2];
    logic [W-1:0] last_val;
    logic         last_ovf;

    task automatic send_cmd(input int n, input logic [1:0] op, input logic [W-1:0] val, input logic cin,
                            output int t_acc);
        bit ok = 0;
        t_acc = -100;
        cmd_op[n] = op; cmd_value[n] = val; cmd_carry_in[n] = cin; cmd_valid[n] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (cmd_ready[n]) begin
                t_acc = cyc; ok = 1; tick();
                break;
            end
            tick();
        end
        cmd_valid[n] = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input int n, output int t_rsp, output bit busy_bad);
        t_rsp = -1; busy_bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid[n]) begin
                t_rsp = cyc;
                break;
            end
            if (cmd_ready[n]) busy_bad = 1;
            tick();
        end
        if (cmd_ready[n]) busy_bad = 1;
    endtask

    task automatic run_cmd(input int n, input logic [1:0] op, input logic [W-1:0] val, input logic cin,
                           input string tag);
        int t0, t_rsp, p0;
        bit busy_bad;
        logic [W-1:0] ev;
        logic ec, eo;
        acc_step(op, exp_acc[n], val, cin, ev, ec, eo);
        exp_acc[n] = ev;
        p0 = n_pulse[n];
        send_cmd(n, op, val, cin, t0);
        wait_rsp(n, t_rsp, busy_bad);
        check({tag, "_latency"}, 64'(t_rsp), 64'(t0 + 2 + lat[n]));
        check({tag, "_pulses"}, 64'(n_pulse[n] - p0), 1);
        check({tag, "_pulse_cyc"}, 64'(last_pulse_cyc[n]), 64'(t0 + 1));
        check({tag, "_pulse_kind"}, last_kind[n], op);
        check({tag, "_busy_ready"}, busy_bad, 0);
        check({tag, "_rsp"}, {rsp_op[n], rsp_value[n], rsp_carry_out[n], rsp_overflow[n]}, {op, ev, ec, eo});
        last_val = rsp_value[n];
        last_ovf = rsp_overflow[n];
        tick();
        check({tag, "_back_idle"}, {rsp_valid[n], cmd_ready[n]}, 2'b01);
    endtask

    initial begin
        int t0, t1, t_rsp, p0;
        bit bad;
        logic [W+4:0] snap;
        logic [W-1:0] ev;
        logic ec, eo;

        lat[0] = LAT0; lat[1] = LAT1;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 5; i++) pipe[n][i] = '0;
            acc_state[n] = '0; exp_acc[n] = '0;
            md_clear[n] = 0; md_inc[n] = 0; md_load[n] = 0; md_value[n] = '0; md_carry[n] = 0; md_ovf[n] = 0;
            inj_clear[n] = 0; inj_inc[n] = 0; inj_load[n] = 0;
            n_pulse[n] = 0; last_pulse_cyc[n] = -1; last_kind[n] = 2'b00;
            reset_n[n] = 1'b0; cmd_valid[n] = 0; cmd_op[n] = '0; cmd_value[n] = '0; cmd_carry_in[n] = 0;
            rsp_ready[n] = 1'b1;
        end
        tick(); tick();
        check("reset_outs_0", outs_vec(0), 0);
        check("reset_outs_1", outs_vec(1), 0);
        reset_n[0] = 1'b1; reset_n[1] = 1'b1;
        repeat (6) tick();
        check("idle_ready", cmd_ready[0], 1);
        check("idle_no_error", protocol_error[0], 0);

        run_cmd(0, K_CLEAR, 8'hA5, 1'b0, "clear");
        check("clear_value", last_val, 8'h00);
        run_cmd(0, K_LOAD, 8'h7F, 1'b0, "load7f");
        run_cmd(0, K_ADD, 8'h01, 1'b0, "add_ovf");
        check("add_ovf_value", {last_val, last_ovf}, {8'h80, 1'b1});
        run_cmd(0, K_LOAD, 8'h00, 1'b0, "load00");
        run_cmd(0, K_SUB, 8'h01, 1'b0, "sub");
        check("sub_value", {last_val, last_ovf}, {8'hFF, 1'b0});

        for (int i = 0; i < 20; i++) begin
            run_cmd(0, 2'($urandom_range(3, 0)), 8'($urandom), 1'($urandom_range(1, 0)), "rand");
        end
        check("clean_no_error", protocol_error[0], 0);

        // Response back-pressure with a second command already waiting.
        rsp_ready[0] = 1'b0;
        acc_step(K_LOAD, exp_acc[0], 8'h5A, 1'b0, ev, ec, eo); exp_acc[0] = ev;
        send_cmd(0, K_LOAD, 8'h5A, 1'b0, t0);
        cmd_op[0] = K_ADD; cmd_value[0] = 8'h03; cmd_carry_in[0] = 1'b0; cmd_valid[0] = 1'b1;
        wait_rsp(0, t_rsp, bad);
        snap = {rsp_op[0], rsp_value[0], rsp_carry_out[0], rsp_overflow[0], rsp_valid[0]};
        p0 = n_pulse[0]; bad = 0;
        repeat (5) begin
            tick();
            if (snap !== {rsp_op[0], rsp_value[0], rsp_carry_out[0], rsp_overflow[0], rsp_valid[0]} || cmd_ready[0])
                bad = 1;
        end
        check("bp_stable", bad, 0);
        check("bp_no_pulse", 64'(n_pulse[0] - p0), 0);
        check("bp_value", {rsp_valid[0], rsp_value[0]}, {1'b1, 8'h5A});
        rsp_ready[0] = 1'b1;
        tick();
        check("bp_release_idle", {rsp_valid[0], cmd_ready[0]}, 2'b01);
        t1 = cyc;
        tick();
        cmd_valid[0] = 1'b0;
        wait_rsp(0, t_rsp, bad);
        check("bp_next_latency", 64'(t_rsp), 64'(t1 + 3));
        check("bp_next_value", rsp_value[0], 8'h5D);
        exp_acc[0] = 8'h5D;
        tick();

        // Stray increment done while idle.
        inj_inc[0] = 1'b1;
        tick();
        inj_inc[0] = 1'b0;
        check("idle_done_error", protocol_error[0], 1);
        repeat (3) tick();
        check("error_sticky", protocol_error[0], 1);

        // Wrong done coincident with the real load done: the load still completes.
        acc_step(K_LOAD, exp_acc[0], 8'h42, 1'b0, ev, ec, eo); exp_acc[0] = ev;
        send_cmd(0, K_LOAD, 8'h42, 1'b0, t0);
        tick();
        inj_clear[0] = 1'b1;
        tick();
        inj_clear[0] = 1'b0;
        check("multi_done_rsp", {rsp_valid[0], rsp_op[0], rsp_value[0]}, {1'b1, K_LOAD, 8'h42});
        tick();

        // Latency-3 instance: plain load, then a wrong done injected during WAIT.
        run_cmd(1, K_LOAD, 8'h10, 1'b0, "l3_load");
        check("l3_no_error", protocol_error[1], 0);
        acc_step(K_LOAD, exp_acc[1], 8'h22, 1'b0, ev, ec, eo); exp_acc[1] = ev;
        send_cmd(1, K_LOAD, 8'h22, 1'b0, t0);
        tick();
        inj_clear[1] = 1'b1;
        tick();
        inj_clear[1] = 1'b0;
        check("wait_wrong_done", {protocol_error[1], rsp_valid[1]}, 2'b10);
        wait_rsp(1, t_rsp, bad);
        check("wait_wrong_latency", 64'(t_rsp), 64'(t0 + 5));
        check("wait_wrong_value", {rsp_op[1], rsp_value[1]}, {K_LOAD, 8'h22});
        tick();

        // Reset during WAIT; the in-flight done lands inside the quiet window.
        acc_step(K_ADD, exp_acc[1], 8'h05, 1'b0, ev, ec, eo); exp_acc[1] = ev;
        send_cmd(1, K_ADD, 8'h05, 1'b0, t0);
        tick();
        reset_n[1] = 1'b0;
        #1;
        check("async_reset_outs", outs_vec(1), 0);
        tick();
        reset_n[1] = 1'b1;
        p0 = n_pulse[1];
        repeat (5) tick();
        check("quiet_no_error", protocol_error[1], 0);
        check("quiet_idle", {cmd_ready[1], rsp_valid[1]}, 2'b10);
        check("quiet_no_pulse", 64'(n_pulse[1] - p0), 0);
        run_cmd(1, K_LOAD, 8'h77, 1'b0, "post_reset");
        check("post_reset_no_error", protocol_error[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
